// File: rtl/uart_mmio_pkg.sv
// uart_pkg: register offsets, status bit positions and TX state encoding for uart_mmio.
package uart_pkg;
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CLRERR = 2'd2;
  localparam logic [1:0] MEMSEL_UART = 2'b11;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_PAR   = 5;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: decoder-side register access bus for the UART window.
interface uart_mmio_if;
  logic [1:0]  mem_sel;
  logic [1:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  modport master (output mem_sel, addr, wr_en, rd_en, wdata, input rdata);
  modport slave (input mem_sel, addr, wr_en, rd_en, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and pollable status.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_mmio_if.slave  bus,
  output logic        tx,
  output logic        irq
);
  localparam int DIV = (CLK_HZ / BAUD < 2) ? 2 : CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  tx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] data_q, fifo_dout;
  logic [FW:0] fifo_cnt;
  logic [31:0] status, rdata_q;
  logic tx_q, ovf_q, sel, push, pop, cnt_end, fifo_full, fifo_empty, busy;
  assign sel = bus.mem_sel == MEMSEL_UART;
  assign push = sel && bus.wr_en && bus.addr == OFF_TXDATA;
  assign cnt_end = cnt_q == CW'(DIV - 1);
  assign busy = state_q != IDLE;
  assign pop = !fifo_empty && (state_q == IDLE || (state_q == STOP && cnt_end));
  assign irq = fifo_cnt == '0 && !busy;
  assign tx = tx_q;
  assign bus.rdata = rdata_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .din_i(bus.wdata),
    .dout_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty), .count_o(fifo_cnt)
  );
  always_comb begin
    status = '0;
    status[ST_PAR] = PAR_EN;
    status[ST_OVF] = ovf_q;
    status[ST_BUSY] = busy;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL] = fifo_full;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (push && fifo_full) ovf_q <= 1'b1;
      else if (sel && bus.wr_en && bus.addr == OFF_CLRERR) ovf_q <= 1'b0;
      if (sel && bus.rd_en) rdata_q <= bus.addr == OFF_STATUS ? status : '0;
    end
  end
  // STOP reloads straight into START so queued bytes go out with no idle gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
    end else begin
      cnt_q <= (state_q == IDLE || cnt_end) ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: if (!fifo_empty) begin
          state_q <= START;
          data_q <= fifo_dout;
          tx_q <= 1'b0;
        end
        START: if (cnt_end) begin
          state_q <= DATA;
          tx_q <= data_q[0];
        end
        DATA: if (cnt_end) begin
          idx_q <= idx_q + 3'd1;
          if (idx_q != 3'd7) tx_q <= data_q[idx_q + 3'd1];
`ifdef UART_TX_PARITY_EN
          else begin
            state_q <= PARITY;
            tx_q <= ^data_q;
          end
`else
          else begin
            state_q <= STOP;
            tx_q <= 1'b1;
          end
`endif
        end
        PARITY: if (cnt_end) begin
          state_q <= STOP;
          tx_q <= 1'b1;
        end
        STOP: if (cnt_end) begin
          state_q <= fifo_empty ? IDLE : START;
          tx_q <= fifo_empty;
          if (!fifo_empty) data_q <= fifo_dout;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio (DIV=10, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
module tb_uart_mmio;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PAR = 32'h20;
`else
  localparam int NB = 10;
  localparam logic [31:0] PAR = 32'h0;
`endif
  localparam int FRAME = DIV * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, irq;
  uart_mmio_if bus();
  uart_mmio #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic rd_seen = 1'b0;
  logic [7:0] exp_tx[$];
  logic [31:0] exp_rd[$];
  int starts[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rst_cnt <= rst_cnt + 1;
    rd_seen <= rst_n && bus.rd_en && bus.mem_sel == 2'b11;
  end

  always @(negedge clk)
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: unexpected read response 0x%0h", bus.rdata);
      end else chk("rdata", bus.rdata, exp_rd.pop_front());
    end

  initial begin : tx_mon
    logic [10:0] obs;
    logic [7:0] e;
    int st, rc;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        rc = rst_cnt;
        obs = '1;
        ok = 1'b1;
        for (int k = 0; k < NB; k++) begin
          repeat (k == 0 ? DIV / 2 : DIV) @(negedge clk);
          if (rst_cnt != rc) begin
            ok = 1'b0;
            break;
          end
          obs[k] = tx;
        end
        if (ok) begin
          starts.push_back(st);
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_frame: unexpected frame 0x%0h expected none", obs);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_frame", 32'(obs), 32'(frame(e)));
          end
        end
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [1:0] a, input logic [7:0] d);
    bus.mem_sel = sel;
    bus.addr = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    bus.mem_sel = 2'b11;
    bus.addr = a;
    bus.rd_en = 1'b1;
    exp_rd.push_back(e);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 8 * FRAME && exp_tx.size() > 0; n++) @(negedge clk);
    chk("drain_tx_queue", 32'(exp_tx.size()), 32'd0);
    repeat (DIV) @(negedge clk);
  endtask

  task automatic timed_frame(input logic [7:0] d, input string tag);
    int t0;
    exp_tx.push_back(d);
    wr(2'b11, 2'd0, d);
    chk({tag, "_tx_before_start"}, 32'(tx), 32'd1);
    @(negedge clk);
    chk({tag, "_start_bit"}, 32'(tx), 32'd0);
    t0 = cyc;
    for (int n = 0; n < 2 * FRAME && !irq; n++) @(negedge clk);
    chk({tag, "_frame_cycles"}, 32'(cyc - t0), 32'(FRAME));
    chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    bus.mem_sel = 2'b00;
    bus.addr = 2'd0;
    bus.wdata = 8'h00;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq), 32'd1);
    chk("reset_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'h04 | PAR);
    rd(2'd0, 32'h0);
    rd(2'd3, 32'h0);
    wr(2'b11, 2'd3, 8'hFF);
    rd(2'd1, 32'h04 | PAR);
    repeat (20) @(negedge clk);
    chk("reserved_write_no_frame", 32'(starts.size()), 32'd0);

    timed_frame(8'hA5, "a5");

    wr(2'b10, 2'd0, 8'h55);
    repeat (30) @(negedge clk);
    chk("wrong_sel_tx", 32'(tx), 32'd1);
    chk("wrong_sel_irq", 32'(irq), 32'd1);
    rd(2'd1, 32'h04 | PAR);

    starts.delete();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_tx.push_back(8'(i));
      wr(2'b11, 2'd0, 8'(i));
    end
    rd(2'd1, 32'h1A | PAR);
    wr(2'b11, 2'd2, 8'h00);
    rd(2'd1, 32'h0A | PAR);
    drain();
    chk("b2b_frame_count", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++)
      chk("b2b_frame_spacing", 32'(starts[i] - starts[i-1]), 32'(FRAME));
    chk("b2b_irq_end", 32'(irq), 32'd1);
    rd(2'd1, 32'h04 | PAR);

    bus.mem_sel = 2'b11;
    bus.addr = 2'd0;
    bus.wdata = 8'h3C;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    exp_rd.push_back(32'h0);
    exp_tx.push_back(8'h3C);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    drain();

    starts.delete();
    wr(2'b11, 2'd0, 8'h81);
    wr(2'b11, 2'd0, 8'h42);
    for (int n = 0; n < 50 && tx; n++) @(negedge clk);
    chk("abort_frame_started", 32'(tx), 32'd0);
    repeat (34) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx_high", 32'(tx), 32'd1);
    chk("abort_irq", 32'(irq), 32'd1);
    rst_n = 1'b1;
    starts.delete();
    repeat (3 * FRAME) @(negedge clk);
    chk("abort_no_frame", 32'(starts.size()), 32'd0);
    chk("abort_tx_idle", 32'(tx), 32'd1);
    rd(2'd1, 32'h04 | PAR);

`ifdef UART_TX_PARITY_EN
    timed_frame(8'h07, "par07");
    rd(2'd1, 32'h24);
`endif
    repeat (5) @(negedge clk);
    chk("all_reads_answered", 32'(exp_rd.size()), 32'd0);
    chk("all_frames_seen", 32'(exp_tx.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART transmitter that sits directly downstream of the address decoder in the MMU.
- It consumes the decoder's UART window: 4 bytes at 0x4000_0000, mem_sel = 2'b11, byte offset on addr[1:0].
- Buffers CPU writes in a small TX FIFO, serialises them on a single tx line, and exposes status for polling.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate. DIV = CLK_HZ/BAUD, integer-truncated, minimum 2.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- mem_sel  in  2  region select from the decoder. This block responds only when it equals 2'b11.
- addr  in  2  byte offset within the UART window.
- wr_en  in  1  write strobe, one cycle per access.
- rd_en  in  1  read strobe, one cycle per access.
- wdata  in  8  write data, byte lane 0.
- rdata  out  32  read data, registered.
- tx  out  1  serial output, idle high.
- irq  out  1  high while the FIFO is empty and the shifter is idle.

Behaviour:
- An access is valid only when mem_sel == 2'b11. Strobes with any other mem_sel are ignored.
- Register map:
  - Offset 0, write: push wdata into the TX FIFO. If the FIFO is full, drop the byte and set sticky overflow.
  - Offset 0, read: returns 0.
  - Offset 1, read: status {26'b0, parity_en, overflow, tx_busy, fifo_empty, fifo_full, 1'b0}, bits [5:0] listed MSB to LSB; bit 0 is reserved and always 0.
  - Offset 2, write (any data): clear overflow.
  - Offset 3: reserved. Reads return 0; writes are ignored.
- Read latency is 1 cycle. rdata updates on the clock edge after rd_en and holds until the next read.
- Simultaneous wr_en and rd_en: both take effect. Status reflects state before the write's edge.
- FIFO:
  - Synchronous, first-in first-out.
  - A push on a full FIFO is dropped even if a pop happens in the same cycle; this is conservative.
  - Push and pop in the same cycle on a non-full FIFO: count is unchanged.
- TX FSM states and transitions:
  - IDLE, to START when the FIFO is not empty: pop one byte, load the shifter, drive tx=0.
  - START, lasts DIV cycles, then DATA.
  - DATA, 8 bits LSB first, DIV cycles each, then STOP (or PARITY when the optional feature is compiled in).
  - STOP, tx=1 for DIV cycles, then IDLE.
- Back-to-back frames: no idle gap. STOP goes straight into START when the FIFO is non-empty at STOP end.
- Baud counter:
  - Counts 0..DIV-1 and reloads at every bit boundary.
  - Width is $clog2(DIV).
  - The bit index is a 3-bit counter that wraps after bit 7.
- tx_busy = (state != IDLE). irq = fifo_empty && !tx_busy, combinational from registered state.
- Reset values: tx=1, rdata=0, irq=1, state=IDLE, FIFO empty, overflow=0, counters=0.
- Reset during a frame aborts it. tx returns high on the reset edge and the FIFO contents are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - tx carries even parity, the XOR of the 8 data bits.
  - Frame is 11 bit-times. Status bit 5 (parity_en) reads 1.
- When undefined:
  - No PARITY state exists.
  - Frame is 10 bit-times. Status bit 5 reads 0.

Decomposition:
- Package uart_pkg holds:
  - Offset constants OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_CLRERR=2'd2.
  - The UART mem_sel code MEMSEL_UART=2'b11.
  - Status bit index constants.
  - tx_state_e enum {IDLE, START, DATA, PARITY, STOP}.
- One sub-module, sync_fifo: parameterised WIDTH and DEPTH, with push/pop/full/empty/count.
- The FSM, baud counter and register decode stay in uart_mmio.

Test Plan (CLK_HZ=1_000_000, BAUD=100_000, so DIV=10; FIFO_DEPTH=4):
- Reset then idle: tx=1, irq=1, and reading offset 1 gives rdata=0x04 (fifo_empty) one cycle later.
- Write 0xA5 at offset 0 with mem_sel=2'b11:
  - tx falls on the next edge and stays low 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1, 10 cycles each.
  - Then high for 10 cycles. Total 100 cycles; irq=1 afterwards.
- Write 0x55 with mem_sel=2'b10: tx stays 1 and the FIFO stays empty.
- Six back-to-back writes 0x01..0x06:
  - The first is popped immediately, 0x02..0x05 fill the FIFO, 0x06 is dropped.
  - Status reads overflow=1 and fifo_full=1.
  - Exactly 5 frames are sent with no idle gaps.
  - A write at offset 2 then clears overflow.
- Assert rst_n low at cycle 35 of a frame: tx=1 on the next edge, the FIFO is empty, and no further frame is sent.
- With UART_TX_PARITY_EN, send 0x07:
  - Parity bit 1 follows the 8 data bits. Frame is 110 cycles.
  - Status bit 5 reads 1.
